// File: rtl/adder_tree_acc_ctrl.sv
// adder_tree_acc_ctrl
// Reduces vectors longer than 32 elements by streaming them as 32-lane chunks.
// Each accepted chunk is summed by a 16-pair adder tree, then registered. The
// registered sum is accumulated across chunks until the last chunk, and the
// result is then held for the consumer.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    chunk handshake; in_data lanes 0-15 = a0..a15, 16-31 = b0..b15
//   in_last              chunk closes the vector
//   abort                synchronous discard of the vector in progress
//   out_valid/out_ready  result handshake
//   out_sum              vector sum mod 2^32
//   out_chunks           chunk count (saturating)
//   out_ovf              sticky accumulator carry-out for this vector
//   busy                 FSM not idle, or a chunk sits in the stage register
module adder_tree_acc_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [32*DATA_W-1:0] in_data,
    input  logic                 in_last,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_sum,
    output logic [CNT_W-1:0]     out_chunks,
    output logic                 out_ovf,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   stage_q, stage_d;
    logic                stage_v_q, stage_v_d;
    logic                stage_last_q, stage_last_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;

    // Adder tree: 16 a+b pairs, then four halving levels. Wraps mod 2^DATA_W.
    logic [DATA_W-1:0] tree_l0 [16];
    logic [DATA_W-1:0] tree_l1 [8];
    logic [DATA_W-1:0] tree_l2 [4];
    logic [DATA_W-1:0] tree_l3 [2];
    logic [DATA_W-1:0] tree_sum;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            tree_l0[i] = in_data[DATA_W*i +: DATA_W] + in_data[DATA_W*(i+16) +: DATA_W];
        end
        for (int i = 0; i < 8; i++) tree_l1[i] = tree_l0[2*i] + tree_l0[2*i+1];
        for (int i = 0; i < 4; i++) tree_l2[i] = tree_l1[2*i] + tree_l1[2*i+1];
        for (int i = 0; i < 2; i++) tree_l3[i] = tree_l2[2*i] + tree_l2[2*i+1];
        tree_sum = tree_l3[0] + tree_l3[1];
    end

    logic              fire;
    logic              first;
    logic [DATA_W-1:0] acc_base;
    logic [DATA_W:0]   acc_add;

    // Once the last chunk is staged, stall input until the result is consumed.
    assign in_ready  = (state_q != StHold) && !(stage_v_q && stage_last_q) && !abort;
    assign fire      = in_valid && in_ready;
    assign first     = (state_q == StIdle);
    assign acc_base  = first ? '0 : acc_q;
    assign acc_add   = {1'b0, acc_base} + {1'b0, stage_q};

    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        stage_v_d    = fire;
        stage_last_d = stage_last_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;

        if (fire) begin
            stage_d      = tree_sum;
            stage_last_d = in_last;
        end

        if (stage_v_q) begin
            acc_d = acc_add[DATA_W-1:0];
            if (first) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            ovf_d = (first ? 1'b0 : ovf_q) | acc_add[DATA_W];
        end

        unique case (state_q)
            StIdle: if (stage_v_q) state_d = stage_last_q ? StHold : StAcc;
            StAcc:  if (stage_v_q && stage_last_q) state_d = StHold;
            StHold: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (abort) begin
            stage_v_d = 1'b0;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            state_d   = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            stage_q      <= '0;
            stage_v_q    <= 1'b0;
            stage_last_q <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            stage_v_q    <= stage_v_d;
            stage_last_q <= stage_last_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    assign out_valid  = (state_q == StHold);
    assign out_sum    = acc_q;
    assign out_chunks = cnt_q;
    assign out_ovf    = ovf_q;
    assign busy       = (state_q != StIdle) || stage_v_q;

endmodule

// File: tb/tb_adder_tree_acc_ctrl.sv
// Directed bench for adder_tree_acc_ctrl with a result scoreboard.
module tb_adder_tree_acc_ctrl;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] in_data;
    logic          in_last;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_sum;
    logic [7:0]    out_chunks;
    logic          out_ovf;
    logic          busy;

    adder_tree_acc_ctrl #(.DATA_W(32), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_chunks (out_chunks),
        .out_ovf    (out_ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] sum;
        logic [7:0]  chunks;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl_acc = 0;
    logic [7:0]  mdl_cnt = 0;
    logic        mdl_ovf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mdl_acc = 0;
        mdl_cnt = 0;
        mdl_ovf = 0;
    endtask

    // Reference: plain lane-by-lane sum, 33-bit accumulate for the carry.
    task automatic model_accept(input logic [31:0] a, input logic [31:0] b, input logic last);
        logic [31:0] t;
        logic [32:0] s;
        t = 0;
        for (int i = 0; i < 32; i++) t = t + ((i < 16) ? a : b);
        s = {1'b0, mdl_acc} + {1'b0, t};
        mdl_acc = s[31:0];
        mdl_ovf = mdl_ovf | s[32];
        if (mdl_cnt != 8'hff) mdl_cnt = mdl_cnt + 8'd1;
        if (last) begin
            sb.push_back('{sum: mdl_acc, chunks: mdl_cnt, ovf: mdl_ovf});
            model_clear();
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic last);
        for (int i = 0; i < 32; i++) in_data[32*i +: 32] = (i < 16) ? a : b;
        in_last  = last;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
        drive(a, b, last);
        for (int n = 0; n < 20 && !in_ready; n++) tick();
        chk("send_ready", 32'(in_ready), 32'd1);
        if (in_ready) begin
            model_accept(a, b, last);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag);
        exp_t e;
        for (int n = 0; n < 20 && !out_valid; n++) tick();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"}, out_sum, e.sum);
            chk({tag, "_chunks"}, 32'(out_chunks), 32'(e.chunks));
            chk({tag, "_ovf"}, 32'(out_ovf), 32'(e.ovf));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
            chk({tag, "_sum_kept"}, out_sum, e.sum);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", out_sum, 32'd0);
        chk("rst_out_chunks", 32'(out_chunks), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: single chunk, latency T+2
        send(32'd1, 32'd2, 1'b1);
        chk("t1_valid_t1", 32'(out_valid), 32'd0);
        tick();
        chk("t1_valid_t2", 32'(out_valid), 32'd1);
        chk("t1_sum_const", out_sum, 32'd48);
        expect_result("t1");

        // 2: four chunks with idle gaps
        for (int k = 1; k <= 4; k++) begin
            send(32'(k), 32'(k), k == 4);
            if (k != 4) begin
                tick();
                tick();
            end
        end
        for (int n = 0; n < 20 && !out_valid; n++) tick();
        chk("t2_sum_const", out_sum, 32'd320);
        expect_result("t2");

        // 3: consumer stalls for 10 cycles while a new chunk is offered
        send(32'd3, 32'd3, 1'b1);
        for (int n = 0; n < 20 && !out_valid; n++) tick();
        chk("t3_valid", 32'(out_valid), 32'd1);
        e = sb.pop_front();
        drive(32'd5, 32'd7, 1'b1);
        for (int n = 0; n < 10; n++) begin
            chk("t3_in_ready_low", 32'(in_ready), 32'd0);
            chk("t3_sum_stable", out_sum, e.sum);
            chk("t3_chunks_stable", 32'(out_chunks), 32'(e.chunks));
            tick();
        end
        chk("t3_sum_96", out_sum, 32'd96);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_in_ready_after", 32'(in_ready), 32'd1);
        if (in_ready) model_accept(32'd5, 32'd7, 1'b1);
        tick();
        in_valid = 1'b0;
        expect_result("t3b");

        // 4: accumulator carry-out, then cleared by the next vector
        send(32'h0400_0000, 32'h0400_0000, 1'b0);
        send(32'h0400_0000, 32'h0400_0000, 1'b1);
        for (int n = 0; n < 20 && !out_valid; n++) tick();
        chk("t4_ovf_const", 32'(out_ovf), 32'd1);
        expect_result("t4a");
        send(32'd0, 32'd0, 1'b1);
        expect_result("t4b");

        // 5: abort discards the vector and refuses the offered chunk
        send(32'd1, 32'd1, 1'b0);
        send(32'd1, 32'd1, 1'b0);
        abort = 1'b1;
        drive(32'd9, 32'd9, 1'b1);
        #1;
        chk("t5_in_ready_abort", 32'(in_ready), 32'd0);
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        model_clear();
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_sum", out_sum, 32'd0);
        chk("t5_chunks", 32'(out_chunks), 32'd0);
        for (int n = 0; n < 3; n++) begin
            chk("t5_no_valid", 32'(out_valid), 32'd0);
            tick();
        end
        send(32'd1, 32'd1, 1'b1);
        for (int n = 0; n < 20 && !out_valid; n++) tick();
        chk("t5_sum_32", out_sum, 32'd32);
        expect_result("t5");

        // 6: asynchronous reset mid-vector
        send(32'd1, 32'd1, 1'b0);
        send(32'd1, 32'd1, 1'b0);
        tick();
        chk("t6_busy_pre", 32'(busy), 32'd1);
        chk("t6_sum_pre", out_sum, 32'd64);
        chk("t6_chunks_pre", 32'(out_chunks), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_rst", 32'(out_valid), 32'd0);
        chk("t6_busy_rst", 32'(busy), 32'd0);
        chk("t6_sum_rst", out_sum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        tick();
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        send(32'd2, 32'd2, 1'b1);
        expect_result("t6");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
